instr_loader: RTL and testbench

Boot-time writer for the fetch-stage instruction memory. Receives a little-endian byte stream (length header followed by instruction words), assembles 32-bit words and issues one write per word into instruction memory at word-aligned byte addresses. Holds the core in reset until a complete, valid image has been loaded. Sits between the host byte link (e.g. UART receiver) and the instruction memory's write port.

---
 rtl/instr_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot loader: assembles a little-endian byte stream (length + words) into instruction memory writes.
// Latency: write strobe 1 cycle after the 4th byte of a word; done 1 cycle after the final strobe/checksum/length.
// Backpressure: rx_ready high only while collecting length, data or checksum bytes; bubbles stall with no timeout.
// Optional checksum byte enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INSTR_COUNT   = 512,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     core_rst_n,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] word_count
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FIN, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_FIN, S_DONE, S_ERR
    } state_t;
`endif

    state_t                   state;
    logic [1:0]               byte_idx;   // position of the next byte within the current 4-byte group
    logic [23:0]              shreg;      // lower three bytes of the group collected so far
    logic [31:0]              len;        // number of words announced by the header
    logic                     accept;
    logic [31:0]              assembled;  // group completed by the byte on rx_data
    logic                     last_word;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]               csum;       // running XOR of header and data bytes
`endif

    assign accept    = rx_valid & rx_ready;
    assign assembled = {rx_data, shreg};
    // word_count still holds the index of the word being completed
    assign last_word = (32'(word_count) + 32'd1) == len;
    assign wr_addr   = ADDRESS_WIDTH'(BASE_ADDR) + (word_count << 2);

    // Loader FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            shreg      <= 24'd0;
            len        <= 32'd0;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;

            // byte assembly is shared by the length header and the data words
            if (accept) begin
                shreg    <= assembled[31:8];
                byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        rx_ready   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        core_rst_n <= 1'b0;
                        byte_idx   <= 2'd0;
                        word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum       <= 8'd0;
`endif
                    end
                end

                S_LEN: begin
                    if (accept && byte_idx == 2'd3) begin
                        len <= assembled;
                        if (assembled == 32'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state      <= S_DONE;
                            rx_ready   <= 1'b0;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
`endif
                        end else if (assembled > 32'(INSTR_COUNT)) begin
                            state    <= S_ERR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept && byte_idx == 2'd3) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_wdata  <= assembled;
                        word_count <= word_count + 1'b1;
                        if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state    <= S_FIN;
                            rx_ready <= 1'b0;
`endif
                        end
                    end
                end

                // one cycle after the final strobe so done never coincides with a write
                S_FIN: begin
                    state      <= S_DONE;
                    done       <= 1'b1;
                    core_rst_n <= 1'b1;
                end

`ifdef INSTR_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a queue-based write model and literal pins.
module tb_instr_loader;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          IC   = 512;
    localparam logic [31:0] BASE = 32'h100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;

    instr_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INSTR_COUNT(IC),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          errors = 0;
    int          checks = 0;
    int          writes_seen = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_data = 32'h0;
    logic [7:0]  last_cs = 8'h00;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Every write strobe must match the next write the model predicts
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_we) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, no write expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_count", word_count, e.idx + 1);
                last_addr = mem_addr;
                last_data = mem_wdata;
            end
        end
    end

    task automatic bubble(input bit with_start);
        rx_valid = 1'b0;
        start    = with_start;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        int   n;
        rx_data  = b;
        rx_valid = 1'b1;
        r = 1'b0;
        n = 0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk); #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: rx_ready stayed 0 for byte %0h, required 1", b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", rx_ready, 1);
        chk("core_rst_after_start", core_rst_n, 0);
        chk("done_after_start", done, 0);
        chk("error_after_start", error, 0);
    endtask

    // Load header n and the words in img; the model predicts writes and final status
    task automatic run_image(input logic [31:0] n, input bit bubbles, input bit bad_csum);
        logic [7:0]  cs;
        logic [31:0] w;
        do_start();
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (bubbles) bubble(1'b0);
            send_byte(n[8*i +: 8]);
            cs = cs ^ n[8*i +: 8];
        end
        if (n > IC) begin
            @(negedge clk);
            chk("err_error", error, 1);
            chk("err_done", done, 0);
            chk("err_ready", rx_ready, 0);
            chk("err_core_rst", core_rst_n, 0);
            return;
        end
        for (int i = 0; i < int'(n); i++)
            exp_q.push_back(wr_t'{BASE + 32'(4 * i), img[i], i});
        for (int i = 0; i < int'(n); i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                // a start pulse during a bubble mid-load must be ignored
                if (bubbles) bubble(i == 0 && j == 2);
                send_byte(w[8*j +: 8]);
                cs = cs ^ w[8*j +: 8];
            end
        end
        last_cs = cs;
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(cs ^ {7'd0, bad_csum});
        @(negedge clk);
        chk("final_done", done, !bad_csum);
        chk("final_error", error, bad_csum);
        chk("final_core_rst", core_rst_n, !bad_csum);
`else
        if (bad_csum) $display("note: checksum disabled, bad_csum ignored");
        if (n > 0) begin
            @(negedge clk);
            chk("strobe_cycle_we", mem_we, 1);
            chk("strobe_cycle_done", done, 0);
        end
        @(negedge clk);
        chk("final_done", done, 1);
        chk("final_error", error, 0);
        chk("final_core_rst", core_rst_n, 1);
`endif
        chk("final_ready", rx_ready, 0);
        chk("all_writes_seen", exp_q.size(), 0);
    endtask

    initial begin
        int base_writes;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rx_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_core_rst", core_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", word_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // two-word image, back to back
        img = '{32'h0000_0013, 32'h0000_006F};
        base_writes = writes_seen;
        run_image(32'd2, 1'b0, 1'b0);
        chk("lit_two_writes", writes_seen - base_writes, 2);
        chk("lit_last_addr", last_addr, 32'h104);
        chk("lit_last_data", last_data, 32'h6F);
        chk("lit_count", word_count, 2);

        // oversize header N = 513
        base_writes = writes_seen;
        run_image(32'd513, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        chk("lit_err_no_write", writes_seen - base_writes, 0);

        // empty image
        img = '{};
        base_writes = writes_seen;
        run_image(32'd0, 1'b0, 1'b0);
        chk("lit_empty_no_write", writes_seen - base_writes, 0);

        // reset mid-word discards the partial word
        do_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_ready", rx_ready, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_core_rst", core_rst_n, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", word_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        img = '{32'h0000_0093};
        run_image(32'd1, 1'b0, 1'b0);
        chk("lit_after_rst_addr", last_addr, 32'h100);
        chk("lit_after_rst_data", last_data, 32'h93);

        // rx_valid toggling every other cycle, with an ignored start
        img = '{32'h1122_3344, 32'hA5A5_0F0F, 32'hFFFF_FFFF};
        base_writes = writes_seen;
        run_image(32'd3, 1'b1, 1'b0);
        chk("lit_bubble_writes", writes_seen - base_writes, 3);
        chk("lit_bubble_last_addr", last_addr, 32'h108);

        // maximum image size
        img = '{};
        for (int i = 0; i < IC; i++) img.push_back($urandom);
        run_image(32'd512, 1'b0, 1'b0);
        chk("lit_max_last_addr", last_addr, 32'h8FC);
        chk("lit_max_count", word_count, 512);

        // one-word image from the checksum example
        img = '{32'h0010_0093};
        run_image(32'd1, 1'b0, 1'b0);
        chk("lit_cs_value", last_cs, 8'h82);
        chk("lit_cs_word", last_data, 32'h0010_0093);
`ifdef INSTR_LOADER_CHECKSUM_EN
        base_writes = writes_seen;
        run_image(32'd1, 1'b0, 1'b1);
        chk("lit_badcs_written", writes_seen - base_writes, 1);
        chk("lit_badcs_error", error, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on total run time
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
